// File: rtl/handshake_const_checker_pkg.sv
// Shared types, slot count and expected-constant masking for the constant checker.
package handshake_const_checker_pkg;

   localparam int unsigned SLOTS = 2;

   typedef logic [1:0] occ_t;
   typedef logic       slot_t;

   function automatic logic [63:0] masked_expected(input logic [63:0]   value,
                                                   input int unsigned width);
      logic [63:0] mask;
      mask = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
      return value & mask;
   endfunction

endpackage

// File: rtl/handshake_ctrl_skid2.sv
// Dataless 2-slot elastic buffer carrying a 1-bit payload, with registered in_ready.
module handshake_ctrl_skid2
   import handshake_const_checker_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic in_valid,
   input  logic in_err,
   output logic in_ready,
   output logic out_valid,
   output logic out_err,
   input  logic out_ready
);

   logic [SLOTS-1:0] err_q;
   slot_t            head_q;
   slot_t            tail_q;
   occ_t             occ_q;
   occ_t             occ_d;
   logic             ready_q;
   logic             in_fire;
   logic             out_fire;

   always_comb begin
      in_fire  = in_valid && ready_q;
      out_fire = (occ_q != '0) && out_ready;
      occ_d    = occ_q;
      if (in_fire && !out_fire) begin
         occ_d = occ_q + 2'd1;
      end else if (!in_fire && out_fire) begin
         occ_d = occ_q - 2'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_q   <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         occ_q   <= '0;
         ready_q <= 1'b1;
      end else begin
         occ_q   <= occ_d;
         // Registered ready looks at post-edge occupancy, so a full buffer reopens one cycle later.
         ready_q <= (occ_d < occ_t'(SLOTS));
         if (in_fire) begin
            err_q[tail_q] <= in_err;
            tail_q        <= ~tail_q;
         end
         if (out_fire) begin
            head_q <= ~head_q;
         end
      end
   end

   assign in_ready  = ready_q;
   assign out_valid = (occ_q != '0);
   assign out_err   = out_valid & err_q[head_q];

endmodule

// File: rtl/handshake_const_checker.sv
// Token-to-control converter that checks each data token against EXPECTED.
// Comparison logic is present only when HANDSHAKE_CONST_CHECK_EN is defined.
module handshake_const_checker
   import handshake_const_checker_pkg::*;
#(
   parameter int unsigned     DATA_WIDTH = 32,
   parameter longint unsigned EXPECTED   = 0,
   parameter int unsigned     CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] ins,
   input  logic                  ins_valid,
   output logic                  ins_ready,
   output logic                  outs_valid,
   input  logic                  outs_ready,
   output logic                  outs_err,
   output logic [CNT_WIDTH-1:0]  token_count,
   output logic                  mismatch,
   output logic [DATA_WIDTH-1:0] first_bad
);

   logic                 err;
   logic                 in_fire;
   logic [CNT_WIDTH-1:0] count_q;

   handshake_ctrl_skid2 u_skid (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (ins_valid),
      .in_err    (err),
      .in_ready  (ins_ready),
      .out_valid (outs_valid),
      .out_err   (outs_err),
      .out_ready (outs_ready)
   );

   assign in_fire = ins_valid && ins_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else if (in_fire && (count_q != '1)) begin
         count_q <= count_q + CNT_WIDTH'(1);
      end
   end

   assign token_count = count_q;

`ifdef HANDSHAKE_CONST_CHECK_EN
   localparam logic [DATA_WIDTH-1:0] ExpMasked =
      DATA_WIDTH'(masked_expected(EXPECTED, DATA_WIDTH));

   logic                  mismatch_q;
   logic [DATA_WIDTH-1:0] first_bad_q;

   assign err = (ins != ExpMasked);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mismatch_q  <= 1'b0;
         first_bad_q <= '0;
      end else if (in_fire && err && !mismatch_q) begin
         mismatch_q  <= 1'b1;
         first_bad_q <= ins;
      end
   end

   assign mismatch  = mismatch_q;
   assign first_bad = first_bad_q;
`else
   localparam logic [63:0] unused_expected = EXPECTED;

   logic unused_ins;
   assign unused_ins = ^ins;

   assign err       = 1'b0;
   assign mismatch  = 1'b0;
   assign first_bad = '0;
`endif

endmodule

// File: tb/tb_handshake_const_checker.sv
// Randomized self-checking bench for handshake_const_checker against a queue-based model.
module tb_handshake_const_checker;

   localparam int unsigned DW   = 6;
   localparam int unsigned CW   = 4;
   localparam int unsigned MAXC = (1 << CW) - 1;
   localparam logic [DW-1:0] EXP = 6'd27;
`ifdef HANDSHAKE_CONST_CHECK_EN
   localparam bit EN = 1'b1;
`else
   localparam bit EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [DW-1:0] ins = '0;
   logic          ins_valid = 1'b0;
   logic          outs_ready = 1'b0;
   logic          ins_ready;
   logic          outs_valid;
   logic          outs_err;
   logic [CW-1:0] token_count;
   logic          mismatch;
   logic [DW-1:0] first_bad;

   int checks   = 0;
   int failures = 0;

   // Reference model: FIFO of err tags plus scalar sticky state.
   bit            mq[$];
   int unsigned   m_count;
   bit            m_mis;
   logic [DW-1:0] m_bad;

   always #5 clk = ~clk;

   handshake_const_checker #(
      .DATA_WIDTH (DW),
      .EXPECTED   (27),
      .CNT_WIDTH  (CW)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .ins         (ins),
      .ins_valid   (ins_valid),
      .ins_ready   (ins_ready),
      .outs_valid  (outs_valid),
      .outs_ready  (outs_ready),
      .outs_err    (outs_err),
      .token_count (token_count),
      .mismatch    (mismatch),
      .first_bad   (first_bad)
   );

   function automatic bit ref_err(input logic [DW-1:0] d);
      return EN && (d != EXP);
   endfunction

   // Expected {outs_valid, outs_err, ins_ready}.
   function automatic logic [2:0] exp_hs();
      bit e;
      e = (mq.size() != 0) ? mq[0] : 1'b0;
      return {mq.size() != 0, e, mq.size() < 2};
   endfunction

   function automatic logic [CW-1:0] exp_cnt();
      return CW'((m_count > MAXC) ? MAXC : m_count);
   endfunction

   // Drive one cycle from a negedge, advance the model, return at the next negedge.
   task automatic cycle(input bit v, input logic [DW-1:0] d, input bit r, output bit acc);
      bit pop;
      ins_valid  = v;
      ins        = d;
      outs_ready = r;
      acc = v && (mq.size() < 2);
      pop = (mq.size() != 0) && r;
      if (pop) void'(mq.pop_front());
      if (acc) begin
         mq.push_back(ref_err(d));
         m_count++;
         if (ref_err(d) && !m_mis) begin
            m_mis = 1'b1;
            m_bad = d;
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst        = 1'b1;
      ins_valid  = 1'b0;
      outs_ready = 1'b0;
      mq.delete();
      m_count = 0;
      m_mis   = 1'b0;
      m_bad   = '0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      #1 rst = 1'b1;
      #2;
      checks++;
      if ({outs_valid, outs_err, ins_ready} !== 3'b001) begin
         failures++;
         $display("FAIL reset_hs got %b want 001", {outs_valid, outs_err, ins_ready});
      end
      checks++;
      if (token_count !== '0) begin
         failures++;
         $display("FAIL reset_count got %0d want 0", token_count);
      end
      checks++;
      if (mismatch !== 1'b0) begin
         failures++;
         $display("FAIL reset_mismatch got %b want 0", mismatch);
      end
      checks++;
      if (first_bad !== '0) begin
         failures++;
         $display("FAIL reset_first_bad got %0d want 0", first_bad);
      end
      do_reset();
   endtask

   task automatic test_match_stream();
      bit acc;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         cycle(i < 3, EXP, 1'b1, acc);
         checks++;
         if ({outs_valid, outs_err, ins_ready} !== exp_hs()) begin
            failures++;
            $display("FAIL match_hs[%0d] got %b want %b", i, {outs_valid, outs_err, ins_ready},
                     exp_hs());
         end
      end
      checks++;
      if (token_count !== CW'(3)) begin
         failures++;
         $display("FAIL match_count got %0d want 3", token_count);
      end
      checks++;
      if (mismatch !== 1'b0) begin
         failures++;
         $display("FAIL match_mismatch got %b want 0", mismatch);
      end
   endtask

   task automatic test_mismatch();
      logic [DW-1:0] toks [4];
      bit acc;
      toks = '{6'd27, 6'd5, 6'd27, 6'd9};
      do_reset();
      for (int i = 0; i < 6; i++) begin
         cycle(i < 4, (i < 4) ? toks[i] : '0, 1'b1, acc);
         checks++;
         if ({outs_valid, outs_err, ins_ready, mismatch} !== {exp_hs(), m_mis}) begin
            failures++;
            $display("FAIL mismatch_seq[%0d] got %b want %b", i,
                     {outs_valid, outs_err, ins_ready, mismatch}, {exp_hs(), m_mis});
         end
      end
      checks++;
      if (first_bad !== (EN ? DW'(5) : DW'(0))) begin
         failures++;
         $display("FAIL mismatch_first_bad got %0d want %0d", first_bad, EN ? 5 : 0);
      end
      checks++;
      if (mismatch !== EN) begin
         failures++;
         $display("FAIL mismatch_sticky got %b want %b", mismatch, EN);
      end
   endtask

   task automatic test_backpressure();
      logic [DW-1:0] toks [3];
      int idx;
      bit acc;
      toks = '{6'd27, 6'd3, 6'd27};
      do_reset();
      idx = 0;
      for (int c = 0; c < 10; c++) begin
         cycle(idx < 3, (idx < 3) ? toks[idx] : '0, c >= 3, acc);
         if (acc) idx++;
         checks++;
         if ({outs_valid, outs_err, ins_ready} !== exp_hs()) begin
            failures++;
            $display("FAIL backpressure_hs[%0d] got %b want %b", c,
                     {outs_valid, outs_err, ins_ready}, exp_hs());
         end
         if (c == 2) begin
            checks++;
            if (ins_ready !== 1'b0) begin
               failures++;
               $display("FAIL backpressure_full_ready got %b want 0", ins_ready);
            end
         end
      end
      checks++;
      if (token_count !== CW'(3)) begin
         failures++;
         $display("FAIL backpressure_count got %0d want 3", token_count);
      end
   endtask

   task automatic test_random();
      int sent;
      int dut_pops;
      int cyc;
      bit v;
      bit r;
      bit acc;
      logic [DW-1:0] d;
      do_reset();
      sent     = 0;
      dut_pops = 0;
      cyc      = 0;
      while ((sent < 1000 || mq.size() != 0) && cyc < 20000) begin
         v = (sent < 1000) && ($urandom_range(0, 3) != 0);
         d = ($urandom_range(0, 1) != 0) ? EXP : DW'($urandom);
         r = ($urandom_range(0, 2) != 0);
         if (outs_valid && r) dut_pops++;
         cycle(v, d, r, acc);
         if (acc) sent++;
         cyc++;
         checks++;
         if ({outs_valid, outs_err, ins_ready} !== exp_hs()) begin
            failures++;
            $display("FAIL random_hs[%0d] got %b want %b", cyc,
                     {outs_valid, outs_err, ins_ready}, exp_hs());
         end
      end
      checks++;
      if (cyc >= 20000) begin
         failures++;
         $display("FAIL random_timeout got sent=%0d want 1000", sent);
      end
      checks++;
      if (dut_pops != 1000) begin
         failures++;
         $display("FAIL random_out_tokens got %0d want 1000", dut_pops);
      end
      checks++;
      if ({token_count, mismatch, first_bad} !== {exp_cnt(), m_mis, m_bad}) begin
         failures++;
         $display("FAIL random_status got %0d/%b/%0d want %0d/%b/%0d", token_count, mismatch,
                  first_bad, exp_cnt(), m_mis, m_bad);
      end
   endtask

   task automatic test_saturation();
      bit acc;
      do_reset();
      for (int i = 0; i < 20; i++) begin
         cycle(1'b1, DW'($urandom), 1'b1, acc);
         checks++;
         if (token_count !== exp_cnt()) begin
            failures++;
            $display("FAIL sat_count[%0d] got %0d want %0d", i, token_count, exp_cnt());
         end
      end
      checks++;
      if (token_count !== CW'(15)) begin
         failures++;
         $display("FAIL sat_final got %0d want 15", token_count);
      end
   endtask

   task automatic test_async_reset();
      bit acc;
      do_reset();
      cycle(1'b1, EXP, 1'b0, acc);
      cycle(1'b1, 6'd26, 1'b0, acc);
      checks++;
      if ({outs_valid, outs_err, ins_ready, mismatch} !== {3'b100, EN}) begin
         failures++;
         $display("FAIL areset_pre got %b want %b", {outs_valid, outs_err, ins_ready, mismatch},
                  {3'b100, EN});
      end
      #2 rst = 1'b1;
      mq.delete();
      m_count = 0;
      m_mis   = 1'b0;
      m_bad   = '0;
      #1;
      checks++;
      if ({outs_valid, outs_err, ins_ready} !== 3'b001) begin
         failures++;
         $display("FAIL areset_hs got %b want 001", {outs_valid, outs_err, ins_ready});
      end
      checks++;
      if ({token_count, mismatch, first_bad} !== '0) begin
         failures++;
         $display("FAIL areset_status got %0d/%b/%0d want 0/0/0", token_count, mismatch,
                  first_bad);
      end
      @(negedge clk);
      rst = 1'b0;
      cycle(1'b0, '0, 1'b1, acc);
      checks++;
      if ({outs_valid, outs_err, ins_ready} !== exp_hs()) begin
         failures++;
         $display("FAIL areset_after got %b want %b", {outs_valid, outs_err, ins_ready},
                  exp_hs());
      end
   endtask

   initial begin
      test_reset();
      test_match_stream();
      test_mismatch();
      test_backpressure();
      test_random();
      test_saturation();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
